// File: rtl/cpu_ad48_trap_pkg.sv
// Shared constants for the cpu_ad48 nested-trap controller: cause encodings,
// priority levels and save-stack field widths.
package cpu_ad48_trap_pkg;

  localparam int unsigned CAUSE_W = 6;
  localparam int unsigned LEVEL_W = 5;
  localparam int unsigned CODE_W  = 4;

  localparam logic [CAUSE_W-1:0] CAUSE_BRK      = 6'h01;
  localparam logic [CAUSE_W-1:0] CAUSE_IRQ_BASE = 6'h10;
  localparam logic [LEVEL_W-1:0] LEVEL_SYNC     = 5'h1F;
  localparam logic [LEVEL_W-1:0] LEVEL_NONE     = 5'h00;

  // Synchronous SYS traps occupy the low cause range.
  function automatic logic [CAUSE_W-1:0] sync_cause(input logic [CODE_W-1:0] code);
    return {2'b00, code};
  endfunction

endpackage

// File: rtl/cpu_ad48_trap_stack.sv
// LIFO of {epc, cause, level} trap-save entries.
// Ports: push/push_* write a new top, pop drops the top, top_wr overwrites the
// top EPC. top_* read the current top (0 when empty); cnt/full/empty report fill.
// Priority inside one cycle: push > pop > top_wr (the controller never mixes them).
module cpu_ad48_trap_stack
  import cpu_ad48_trap_pkg::*;
#(
  parameter int unsigned XLEN  = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  logic [XLEN-1:0]    push_epc,
  input  logic [CAUSE_W-1:0] push_cause,
  input  logic [LEVEL_W-1:0] push_level,
  input  logic               pop,
  input  logic               top_wr,
  input  logic [XLEN-1:0]    top_wdata,
  output logic [XLEN-1:0]    top_epc,
  output logic [CAUSE_W-1:0] top_cause,
  output logic [LEVEL_W-1:0] top_level,
  output logic [CNT_W-1:0]   cnt,
  output logic               full,
  output logic               empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [XLEN-1:0]    epc_q   [DEPTH];
  logic [CAUSE_W-1:0] cause_q [DEPTH];
  logic [LEVEL_W-1:0] level_q [DEPTH];
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   top_idx;
  logic [IDX_W-1:0]   push_idx;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign cnt      = cnt_q;
  assign top_idx  = IDX_W'(cnt_q - CNT_W'(1));
  assign push_idx = IDX_W'(cnt_q);

  assign top_epc   = empty ? '0 : epc_q[top_idx];
  assign top_cause = empty ? '0 : cause_q[top_idx];
  assign top_level = empty ? '0 : level_q[top_idx];

  // Storage and fill counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        epc_q[i]   <= '0;
        cause_q[i] <= '0;
        level_q[i] <= '0;
      end
    end else if (push && !full) begin
      epc_q[push_idx]   <= push_epc;
      cause_q[push_idx] <= push_cause;
      level_q[push_idx] <= push_level;
      cnt_q             <= cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else if (top_wr && !empty) begin
      epc_q[top_idx] <= top_wdata;
    end
  end

endmodule

// File: rtl/cpu_ad48_trap_nest_ctrl.sv
// Nested trap controller for cpu_ad48: arbitrates SYS traps, IRET, prioritised
// IRQs and CSR EPC writes against a save stack, and issues PC redirects.
// Ports: irq/irq_en/gie IRQ request+masks; sync_* SYS trap commit; irq_pc EPC
// for IRQs; iret_valid IRET commit; epc_wr/epc_wdata CSR write to stack-top EPC.
// Outputs: redirect_valid/redirect_pc (registered, latency 1), epc_top/cause_top
// (stack top, 0 when empty), depth, cur_level, handler_active, iret_err pulse,
// sticky fatal_halt.
module cpu_ad48_trap_nest_ctrl
  import cpu_ad48_trap_pkg::*;
#(
  parameter int unsigned     XLEN        = 48,
  parameter int unsigned     IRQ_LINES   = 4,
  parameter int unsigned     NEST_DEPTH  = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(64),
  parameter int unsigned     VECTORED    = 0,
  parameter int unsigned     VEC_STRIDE  = 4,
  localparam int unsigned    DEPTH_W     = $clog2(NEST_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [IRQ_LINES-1:0] irq,
  input  logic [IRQ_LINES-1:0] irq_en,
  input  logic                 gie,
  input  logic                 sync_valid,
  input  logic [CODE_W-1:0]    sync_code,
  input  logic [XLEN-1:0]      sync_pc,
  input  logic [XLEN-1:0]      irq_pc,
  input  logic                 iret_valid,
  input  logic                 epc_wr,
  input  logic [XLEN-1:0]      epc_wdata,
  output logic                 redirect_valid,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [XLEN-1:0]      epc_top,
  output logic [CAUSE_W-1:0]   cause_top,
  output logic [DEPTH_W-1:0]   depth,
  output logic [LEVEL_W-1:0]   cur_level,
  output logic                 handler_active,
  output logic                 iret_err,
  output logic                 fatal_halt
);

  logic               irq_hit;
  logic [3:0]         irq_idx;
  logic               do_sync, do_iret, do_irq, do_trap;
  logic               push, pop, top_wr;
  logic [CAUSE_W-1:0] trap_cause;
  logic [LEVEL_W-1:0] trap_level;
  logic [XLEN-1:0]    trap_epc;
  logic [XLEN-1:0]    vector;
  logic [LEVEL_W-1:0] stk_top_level;
  logic               stk_full, stk_empty;

  // Highest-index eligible IRQ line wins (ascending scan, last hit kept).
  always_comb begin
    irq_hit = 1'b0;
    irq_idx = '0;
    for (int i = 0; i < int'(IRQ_LINES); i++) begin
      if (gie && irq_en[i] && irq[i] && (LEVEL_W'(i + 1) > cur_level)) begin
        irq_hit = 1'b1;
        irq_idx = 4'(i);
      end
    end
  end

  // Event priority: fatal_halt > sync > IRET > IRQ > EPC write. IRQs are held
  // off in the redirect cycle so redirect_valid never pulses back to back;
  // the line is level-held and is taken the cycle after.
  always_comb begin
    do_sync = !fatal_halt && sync_valid;
    do_iret = !fatal_halt && !sync_valid && iret_valid;
    do_irq  = !fatal_halt && !sync_valid && !iret_valid && irq_hit && !redirect_valid;
    do_trap = do_sync || do_irq;
    push    = do_trap && !stk_full;
    pop     = do_iret && !stk_empty;
    top_wr  = !fatal_halt && !sync_valid && !iret_valid && !do_irq && epc_wr;
  end

  always_comb begin
    trap_cause = do_sync ? sync_cause(sync_code) : CAUSE_IRQ_BASE + CAUSE_W'(irq_idx);
    trap_level = do_sync ? LEVEL_SYNC : LEVEL_W'(irq_idx) + LEVEL_W'(1);
    trap_epc   = do_sync ? sync_pc : irq_pc;
    vector     = TRAP_VECTOR;
    if (VECTORED != 0) begin
      vector = TRAP_VECTOR + XLEN'(trap_cause) * XLEN'(VEC_STRIDE);
    end
  end

  cpu_ad48_trap_stack #(
    .XLEN  (XLEN),
    .DEPTH (NEST_DEPTH)
  ) u_stack (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_epc   (trap_epc),
    .push_cause (trap_cause),
    .push_level (cur_level),
    .pop        (pop),
    .top_wr     (top_wr),
    .top_wdata  (epc_wdata),
    .top_epc    (epc_top),
    .top_cause  (cause_top),
    .top_level  (stk_top_level),
    .cnt        (depth),
    .full       (stk_full),
    .empty      (stk_empty)
  );

  assign handler_active = !stk_empty;

  // Redirect, level, error and halt registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      cur_level      <= LEVEL_NONE;
      iret_err       <= 1'b0;
      fatal_halt     <= 1'b0;
    end else begin
      redirect_valid <= push || pop;
      redirect_pc    <= push ? vector : (pop ? epc_top : '0);
      if (push) begin
        cur_level <= trap_level;
      end else if (pop) begin
        cur_level <= stk_top_level;
      end
      iret_err <= do_iret && stk_empty;
      if (do_trap && stk_full) begin
        fatal_halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_ad48_trap_nest_ctrl.sv
// Directed bench for cpu_ad48_trap_nest_ctrl: default instance plus a VECTORED
// instance sharing the same stimulus.
module tb_cpu_ad48_trap_nest_ctrl;
  import cpu_ad48_trap_pkg::*;

  localparam int unsigned XLEN = 48;

  logic            clk = 1'b0;
  logic            resetn;
  logic [3:0]      irq, irq_en;
  logic            gie, sync_valid, iret_valid, epc_wr;
  logic [3:0]      sync_code;
  logic [XLEN-1:0] sync_pc, irq_pc, epc_wdata;

  logic            rv0, rv1;
  logic [XLEN-1:0] rpc0, rpc1, epc0, epc1;
  logic [5:0]      cause0, cause1;
  logic [2:0]      depth0, depth1;
  logic [4:0]      lvl0, lvl1;
  logic            ha0, ha1, ierr0, ierr1, fh0, fh1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_ad48_trap_nest_ctrl dut0 (
    .clk(clk), .resetn(resetn), .irq(irq), .irq_en(irq_en), .gie(gie),
    .sync_valid(sync_valid), .sync_code(sync_code), .sync_pc(sync_pc),
    .irq_pc(irq_pc), .iret_valid(iret_valid), .epc_wr(epc_wr), .epc_wdata(epc_wdata),
    .redirect_valid(rv0), .redirect_pc(rpc0), .epc_top(epc0), .cause_top(cause0),
    .depth(depth0), .cur_level(lvl0), .handler_active(ha0), .iret_err(ierr0),
    .fatal_halt(fh0)
  );

  cpu_ad48_trap_nest_ctrl #(.VECTORED(1), .VEC_STRIDE(4)) dut1 (
    .clk(clk), .resetn(resetn), .irq(irq), .irq_en(irq_en), .gie(gie),
    .sync_valid(sync_valid), .sync_code(sync_code), .sync_pc(sync_pc),
    .irq_pc(irq_pc), .iret_valid(iret_valid), .epc_wr(epc_wr), .epc_wdata(epc_wdata),
    .redirect_valid(rv1), .redirect_pc(rpc1), .epc_top(epc1), .cause_top(cause1),
    .depth(depth1), .cur_level(lvl1), .handler_active(ha1), .iret_err(ierr1),
    .fatal_halt(fh1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sync_valid = 1'b0;
    iret_valid = 1'b0;
    epc_wr     = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; irq = '0; irq_en = 4'hF; gie = 1'b1;
    sync_valid = 1'b0; sync_code = 4'h0; sync_pc = '0; irq_pc = '0;
    iret_valid = 1'b0; epc_wr = 1'b0; epc_wdata = '0;
    tick(); tick();
    chk("rst_rv", 64'(rv0), 64'd0);
    chk("rst_rpc", 64'(rpc0), 64'd0);
    chk("rst_epc", 64'(epc0), 64'd0);
    chk("rst_cause", 64'(cause0), 64'd0);
    chk("rst_depth", 64'(depth0), 64'd0);
    chk("rst_level", 64'(lvl0), 64'd0);
    chk("rst_ha", 64'(ha0), 64'd0);
    chk("rst_fh", 64'(fh0), 64'd0);
    resetn = 1'b1;
    tick();

    // Two nested breakpoints
    sync_valid = 1'b1; sync_code = CAUSE_BRK[3:0]; sync_pc = 48'd0;
    tick(); idle();
    chk("brk1_rv", 64'(rv0), 64'd1);
    chk("brk1_pc", 64'(rpc0), 64'd64);
    chk("brk1_depth", 64'(depth0), 64'd1);
    chk("brk1_cause", 64'(cause0), 64'h01);
    chk("brk1_level", 64'(lvl0), 64'h1F);
    tick();
    chk("brk1_pulse", 64'(rv0), 64'd0);
    sync_valid = 1'b1; sync_pc = 48'd72;
    tick(); idle();
    chk("brk2_pc", 64'(rpc0), 64'd64);
    chk("brk2_depth", 64'(depth0), 64'd2);
    chk("brk2_epc", 64'(epc0), 64'd72);
    tick();
    epc_wr = 1'b1; epc_wdata = 48'd73;
    tick(); idle();
    chk("epcwr_epc", 64'(epc0), 64'd73);
    chk("epcwr_rv", 64'(rv0), 64'd0);
    iret_valid = 1'b1;
    tick(); idle();
    chk("iret1_rv", 64'(rv0), 64'd1);
    chk("iret1_pc", 64'(rpc0), 64'd73);
    chk("iret1_depth", 64'(depth0), 64'd1);
    chk("iret1_level", 64'(lvl0), 64'h1F);
    tick();
    iret_valid = 1'b1;
    tick(); idle();
    chk("iret2_rv", 64'(rv0), 64'd1);
    chk("iret2_pc", 64'(rpc0), 64'd0);
    chk("iret2_depth", 64'(depth0), 64'd0);
    chk("iret2_ha", 64'(ha0), 64'd0);
    chk("iret2_level", 64'(lvl0), 64'd0);
    tick();

    // Preemption
    irq = 4'b0010; irq_pc = 48'd100;
    tick();
    chk("pre1_rv", 64'(rv0), 64'd1);
    chk("pre1_level", 64'(lvl0), 64'd2);
    chk("pre1_cause", 64'(cause0), 64'h11);
    irq = 4'b0011;
    tick();
    chk("pre_low_rv0", 64'(rv0), 64'd0);
    tick();
    chk("pre_low_rv1", 64'(rv0), 64'd0);
    chk("pre_low_depth", 64'(depth0), 64'd1);
    irq = 4'b1011; irq_pc = 48'd200;
    tick();
    chk("pre3_rv", 64'(rv0), 64'd1);
    chk("pre3_pc", 64'(rpc0), 64'd64);
    chk("pre3_level", 64'(lvl0), 64'd4);
    chk("pre3_depth", 64'(depth0), 64'd2);
    chk("pre3_cause", 64'(cause0), 64'h13);
    irq = 4'b0001;
    tick();
    iret_valid = 1'b1;
    tick(); idle();
    chk("pre_iret1_pc", 64'(rpc0), 64'd200);
    chk("pre_iret1_level", 64'(lvl0), 64'd2);
    tick();
    chk("pre_hold_rv", 64'(rv0), 64'd0);
    iret_valid = 1'b1; irq_pc = 48'd300;
    tick(); idle();
    chk("pre_iret2_pc", 64'(rpc0), 64'd100);
    chk("pre_iret2_level", 64'(lvl0), 64'd0);
    chk("pre_iret2_depth", 64'(depth0), 64'd0);
    tick();
    chk("pre_irq0_holdoff", 64'(rv0), 64'd0);
    tick();
    chk("pre_irq0_rv", 64'(rv0), 64'd1);
    chk("pre_irq0_level", 64'(lvl0), 64'd1);
    chk("pre_irq0_cause", 64'(cause0), 64'h10);
    irq = '0;
    tick();
    iret_valid = 1'b1;
    tick(); idle();
    chk("pre_end_pc", 64'(rpc0), 64'd300);
    chk("pre_end_depth", 64'(depth0), 64'd0);
    tick();

    // IRET at depth 0
    iret_valid = 1'b1;
    tick(); idle();
    chk("ierr_pulse", 64'(ierr0), 64'd1);
    chk("ierr_rv", 64'(rv0), 64'd0);
    chk("ierr_depth", 64'(depth0), 64'd0);
    tick();
    chk("ierr_clear", 64'(ierr0), 64'd0);

    // Simultaneous sync and IRQ
    sync_valid = 1'b1; sync_pc = 48'd500; irq = 4'b0100; irq_pc = 48'd600;
    tick(); idle();
    chk("sim_rv", 64'(rv0), 64'd1);
    chk("sim_cause", 64'(cause0), 64'h01);
    chk("sim_level", 64'(lvl0), 64'h1F);
    tick();
    chk("sim_blocked", 64'(rv0), 64'd0);
    sync_valid = 1'b1; sync_pc = 48'd504;
    tick(); idle();
    chk("sim2_depth", 64'(depth0), 64'd2);
    tick();
    iret_valid = 1'b1;
    tick(); idle();
    chk("sim_iret1_pc", 64'(rpc0), 64'd504);
    tick();
    chk("sim_still_blocked", 64'(rv0), 64'd0);
    iret_valid = 1'b1;
    tick(); idle();
    chk("sim_iret2_pc", 64'(rpc0), 64'd500);
    chk("sim_iret2_depth", 64'(depth0), 64'd0);
    tick();
    tick();
    chk("sim_irq_rv", 64'(rv0), 64'd1);
    chk("sim_irq_cause", 64'(cause0), 64'h12);
    chk("sim_irq_level", 64'(lvl0), 64'd3);
    chk("sim_irq_epc", 64'(epc0), 64'd600);
    irq = '0;
    tick();
    iret_valid = 1'b1;
    tick(); idle();
    tick();
    chk("sim_end_depth", 64'(depth0), 64'd0);

    // Overflow
    for (int k = 0; k < 4; k++) begin
      sync_valid = 1'b1; sync_pc = 48'(1000 + k);
      tick(); idle();
      chk("ovf_rv", 64'(rv0), 64'd1);
      chk("ovf_depth", 64'(depth0), 64'(k + 1));
      tick();
    end
    sync_valid = 1'b1; sync_pc = 48'd2000;
    tick(); idle();
    chk("ovf5_rv", 64'(rv0), 64'd0);
    chk("ovf5_depth", 64'(depth0), 64'd4);
    chk("ovf5_fh", 64'(fh0), 64'd1);
    chk("ovf5_epc", 64'(epc0), 64'd1003);
    iret_valid = 1'b1;
    tick(); idle();
    chk("ovf_iret_rv", 64'(rv0), 64'd0);
    chk("ovf_iret_depth", 64'(depth0), 64'd4);
    tick();
    chk("ovf_sticky", 64'(fh0), 64'd1);

    // Vectored dispatch, then reset mid-handler
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("rst2_fh", 64'(fh0), 64'd0);
    tick();
    irq = 4'b0010;
    tick();
    chk("vec_rv", 64'(rv1), 64'd1);
    chk("vec_pc", 64'(rpc1), 64'd132);
    chk("nonvec_pc", 64'(rpc0), 64'd64);
    irq = 4'b1010;
    tick();
    tick();
    chk("vec2_pc", 64'(rpc1), 64'd140);
    chk("vec2_depth", 64'(depth1), 64'd2);
    #2 resetn = 1'b0;
    #1;
    chk("arst_rv", 64'(rv1), 64'd0);
    chk("arst_rpc", 64'(rpc1), 64'd0);
    chk("arst_depth", 64'(depth1), 64'd0);
    chk("arst_ha", 64'(ha1), 64'd0);
    chk("arst_epc", 64'(epc1), 64'd0);
    chk("arst_cause", 64'(cause1), 64'd0);
    chk("arst_level", 64'(lvl1), 64'd0);
    chk("arst_depth0", 64'(depth0), 64'd0);
    chk("arst_misc", 64'({ierr1, fh1}), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
